iir_filter_bank: RTL and testbench

Parametrised multi-channel first-order IIR filter bank that replaces the fixed pair of per-filter instances with one time-multiplexed datapath. Every channel filters the same input sample stream, and each channel has its own runtime-programmable coefficients. A single shared multiply-accumulate unit is sequenced by an FSM. Valid/ready handshakes sit on both the sample-source side (ROM sequencer) and the output side. Saturation is flagged per channel.

---
 rtl/iir_filter_bank_pkg.sv | 35 +++
 rtl/iir_filter_bank_if.sv | 28 ++
 rtl/iir_filter_bank_mac.sv | 62 ++++++
 rtl/iir_filter_bank.sv | 170 +++++++++++++++++
 tb/tb_iir_filter_bank.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/iir_filter_bank_pkg.sv
// Shared types and helpers for the time-multiplexed IIR filter bank.
// Coefficients arrive in sign-magnitude and are converted to two's complement here.
package iir_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    COMMIT = 2'd2,
    OUT    = 2'd3
  } state_e;

  // Step order inside MAC matches the coefficient selector encoding.
  typedef enum logic [1:0] {
    B0 = 2'd0,
    B1 = 2'd1,
    A1 = 2'd2
  } coef_sel_e;

  // Two guard bits over the full product width, so three accumulated products cannot overflow.
  function automatic int acc_w(input int data_w);
    return 2 * data_w + 2;
  endfunction

  // Width-generic up to 32 bits; negative zero naturally maps to zero.
  function automatic logic [31:0] sm_to_tc(input logic [31:0] sm, input int width);
    logic [31:0] mag;
    mag = sm & ((32'd1 << (width - 1)) - 32'd1);
    if (sm[width - 1]) begin
      return 32'd0 - mag;
    end else begin
      return mag;
    end
  endfunction

endpackage

// File: rtl/iir_filter_bank_if.sv
// Sample, coefficient and result handshake bundle of the IIR filter bank.
interface iir_filter_bank_if #(
  parameter int DATA_W = 16,
  parameter int N_CH   = 2,
  parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
);
  logic                     in_valid;
  logic                     in_ready;
  logic [DATA_W-1:0]        in_data;
  logic                     cfg_we;
  logic [CH_W-1:0]          cfg_ch;
  logic [1:0]               cfg_sel;
  logic [DATA_W-1:0]        cfg_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [N_CH*DATA_W-1:0]   out_data;
  logic [N_CH-1:0]          out_sat;

  modport master (
    output in_valid, in_data, cfg_we, cfg_ch, cfg_sel, cfg_data, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, in_data, cfg_we, cfg_ch, cfg_sel, cfg_data, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/iir_filter_bank_mac.sv
// Shared multiply-accumulate unit: one product per enabled cycle, then round half up and saturate.
module iir_mac
  import iir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] sample_i,
  input  logic [DATA_W-1:0] coef_i,
  input  logic              clear_i,
  input  logic              en_i,
  output logic [DATA_W-1:0] result_o,
  output logic              sat_o
);
  localparam int ACC_W = acc_w(DATA_W);
  localparam logic signed [ACC_W-1:0] HALF_C = ACC_W'(1) <<< (FRAC_W - 1);
  localparam logic signed [ACC_W-1:0] MAX_C  = ACC_W'((64'sd1 <<< (DATA_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] MIN_C  = ~MAX_C;

  logic [31:0]                coef_full_s;
  logic signed [DATA_W-1:0]   coef_tc_s;
  logic                       unused_coef_s;
  logic signed [2*DATA_W-1:0] prod_s;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    sum_s;
  logic signed [ACC_W-1:0]    rnd_s;

  assign coef_full_s   = sm_to_tc(32'(coef_i), DATA_W);
  assign coef_tc_s     = coef_full_s[DATA_W-1:0];
  assign unused_coef_s = ^coef_full_s[31:DATA_W];
  assign prod_s        = (2*DATA_W)'($signed(sample_i)) * (2*DATA_W)'(coef_tc_s);

  // Clear restarts the sum with the current product rather than zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else if (en_i) begin
      acc_q <= (clear_i ? '0 : acc_q) + ACC_W'(prod_s);
    end else begin
      acc_q <= acc_q;
    end
  end

  assign sum_s = acc_q + HALF_C;
  assign rnd_s = sum_s >>> FRAC_W;

  always_comb begin
    if (rnd_s > MAX_C) begin
      result_o = MAX_C[DATA_W-1:0];
      sat_o    = 1'b1;
    end else if (rnd_s < MIN_C) begin
      result_o = MIN_C[DATA_W-1:0];
      sat_o    = 1'b1;
    end else begin
      result_o = rnd_s[DATA_W-1:0];
      sat_o    = 1'b0;
    end
  end

endmodule

// File: rtl/iir_filter_bank.sv
// Multi-channel first-order IIR filter bank sharing one MAC across all channels.
// Each channel costs three MAC cycles plus one commit cycle per accepted sample.
module iir_filter_bank
  import iir_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int N_CH   = 2
) (
  input logic              clk,
  input logic              rst,
  iir_filter_bank_if.slave bus
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_MAC    = MAC;
  localparam logic [1:0] S_COMMIT = COMMIT;
  localparam logic [1:0] S_OUT    = OUT;

  logic [1:0]             state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [1:0]             step_q, step_d;
  logic                   in_ready_q, out_valid_q;
  logic [DATA_W-1:0]      x_q;
  logic [N_CH*DATA_W-1:0] out_data_q;
  logic [N_CH-1:0]        out_sat_q;
  logic [DATA_W-1:0]      shadow_q [N_CH][3];
  logic [DATA_W-1:0]      active_q [N_CH][3];
  logic [DATA_W-1:0]      x1_q [N_CH];
  logic [DATA_W-1:0]      y1_q [N_CH];

  logic                   accept_s, cfg_hit_s, mac_en_s, mac_clr_s, mac_sat_s;
  logic [DATA_W-1:0]      mac_sample_s, mac_coef_s, mac_res_s;

  // in_ready_q is only high in IDLE, and stays low in the first cycle after reset release.
  assign accept_s  = in_ready_q && bus.in_valid;
  assign cfg_hit_s = bus.cfg_we && (bus.cfg_sel != 2'd3) && (int'(bus.cfg_ch) < N_CH);
  assign mac_en_s  = (state_q == S_MAC);
  assign mac_clr_s = (step_q == 2'd0);

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          state_d = S_MAC;
          ch_d    = '0;
          step_d  = 2'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MAC: begin
        if (step_q == 2'd2) begin
          state_d = S_COMMIT;
          step_d  = 2'd0;
        end else begin
          step_d  = step_q + 2'd1;
        end
      end
      S_COMMIT: begin
        if (ch_q == CH_W'(N_CH - 1)) begin
          state_d = S_OUT;
        end else begin
          state_d = S_MAC;
          ch_d    = ch_q + CH_W'(1);
        end
      end
      S_OUT: begin
        if (bus.out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      step_q      <= 2'd0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      step_q      <= step_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= (state_d == S_OUT);
    end
  end

  // Writes always land in shadow; the accept edge snapshots the pre-write shadow into active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_CH; k++) begin
        for (int s = 0; s < 3; s++) begin
          shadow_q[k][s] <= '0;
          active_q[k][s] <= '0;
        end
      end
    end else begin
      if (cfg_hit_s) begin
        shadow_q[bus.cfg_ch][bus.cfg_sel] <= bus.cfg_data;
      end
      if (accept_s) begin
        active_q <= shadow_q;
      end
    end
  end

  always_comb begin
    mac_sample_s = x_q;
    case (step_q)
      B0:      mac_sample_s = x_q;
      B1:      mac_sample_s = x1_q[ch_q];
      A1:      mac_sample_s = y1_q[ch_q];
      default: mac_sample_s = x_q;
    endcase
  end

  assign mac_coef_s = (step_q == 2'd3) ? '0 : active_q[ch_q][step_q];

  iir_mac #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .sample_i (mac_sample_s),
    .coef_i   (mac_coef_s),
    .clear_i  (mac_clr_s),
    .en_i     (mac_en_s),
    .result_o (mac_res_s),
    .sat_o    (mac_sat_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q        <= '0;
      out_data_q <= '0;
      out_sat_q  <= '0;
      for (int k = 0; k < N_CH; k++) begin
        x1_q[k] <= '0;
        y1_q[k] <= '0;
      end
    end else begin
      if (accept_s) begin
        x_q <= bus.in_data;
      end
      if (state_q == S_COMMIT) begin
        out_data_q[ch_q*DATA_W +: DATA_W] <= mac_res_s;
        out_sat_q[ch_q]                   <= mac_sat_s;
        x1_q[ch_q]                        <= x_q;
        y1_q[ch_q]                        <= mac_res_s;
      end
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;

endmodule

// File: tb/tb_iir_filter_bank.sv
// Self-checking bench for iir_filter_bank: directed cases plus randomized samples and
// coefficients, checked against an integer-arithmetic model of the filter equations.
module tb_iir_filter_bank;
  localparam int DATA_W = 16;
  localparam int FRAC_W = 8;
  localparam int N_CH   = 2;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  int                sh_m  [N_CH][3];
  int                act_m [N_CH][3];
  int                x1_m  [N_CH];
  int                y1_m  [N_CH];
  logic [DATA_W-1:0] exp_y [N_CH];
  logic              exp_sat [N_CH];
  bit                acc_flag;

  iir_filter_bank_if #(.DATA_W(DATA_W), .N_CH(N_CH)) bus ();

  iir_filter_bank #(.DATA_W(DATA_W), .FRAC_W(FRAC_W), .N_CH(N_CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int to_int(input logic [DATA_W-1:0] v);
    if (v[DATA_W-1]) return int'(v) - (1 << DATA_W);
    else return int'(v);
  endfunction

  function automatic int sm_val(input int v);
    if (v >= (1 << (DATA_W - 1))) return -(v - (1 << (DATA_W - 1)));
    else return v;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < N_CH; k++) begin
      for (int s = 0; s < 3; s++) begin
        sh_m[k][s]  = 0;
        act_m[k][s] = 0;
      end
      x1_m[k] = 0;
      y1_m[k] = 0;
    end
  endfunction

  // y = b0*x + b1*x[n-1] + a1*y[n-1], rounded half up at FRAC_W and clamped to DATA_W.
  function automatic void model_accept(input logic [DATA_W-1:0] x);
    int     xi;
    int     lim;
    longint acc;
    longint y;
    xi  = to_int(x);
    lim = 1 << (DATA_W - 1);
    for (int k = 0; k < N_CH; k++) begin
      for (int s = 0; s < 3; s++) act_m[k][s] = sh_m[k][s];
      acc = longint'(sm_val(act_m[k][0])) * xi
          + longint'(sm_val(act_m[k][1])) * x1_m[k]
          + longint'(sm_val(act_m[k][2])) * y1_m[k];
      y = (acc + (longint'(1) << (FRAC_W - 1))) >>> FRAC_W;
      exp_sat[k] = (y > lim - 1) || (y < -lim);
      if (y > lim - 1) y = lim - 1;
      else if (y < -lim) y = -lim;
      exp_y[k] = DATA_W'(y);
      x1_m[k]  = xi;
      y1_m[k]  = int'(y);
    end
  endfunction

  // All driving tasks start and end at a falling clock edge.
  task automatic cfg_write(input int ch, input int sel, input logic [DATA_W-1:0] d);
    bus.cfg_we   = 1'b1;
    bus.cfg_ch   = CH_W'(ch);
    bus.cfg_sel  = 2'(sel);
    bus.cfg_data = d;
    @(negedge clk);
    bus.cfg_we   = 1'b0;
    if (sel < 3) sh_m[ch][sel] = int'(d);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);
    check("rst_sat", bus.out_sat, 0);
    check("rst_ready", bus.in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    model_reset();
    bus.in_valid  = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.out_ready = 1'b1;
    rst = 1'b0;
    #1 check("ready_before_edge", bus.in_ready, 0);
    @(negedge clk);
    check("ready_after_release", bus.in_ready, 1);
  endtask

  task automatic send(input logic [DATA_W-1:0] x, input int stall, input bit pend,
                      input logic [DATA_W-1:0] pend_x);
    int                     lat;
    logic [N_CH*DATA_W-1:0] held_d;
    logic [N_CH-1:0]        held_s;
    bus.out_ready = (stall == 0);
    bus.in_valid  = 1'b1;
    bus.in_data   = x;
    lat = 0;
    while (!bus.in_ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model_accept(x);
    acc_flag = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 4 * N_CH + 1);
    for (int k = 0; k < N_CH; k++) begin
      check($sformatf("data_ch%0d", k), bus.out_data[k*DATA_W +: DATA_W], exp_y[k]);
      check($sformatf("sat_ch%0d", k), bus.out_sat[k], exp_sat[k]);
    end
    held_d = bus.out_data;
    held_s = bus.out_sat;
    for (int i = 0; i < stall; i++) begin
      if (pend) begin
        bus.in_valid = 1'b1;
        bus.in_data  = pend_x;
      end
      @(negedge clk);
      check("hold_data", bus.out_data, held_d);
      check("hold_sat", bus.out_sat, held_s);
      check("hold_valid", bus.out_valid, 1);
      check("hold_ready", bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    if (stall > 0) check("ready_at_release", bus.in_ready, 0);
    @(negedge clk);
    check("ready_after_xfer", bus.in_ready, 1);
    check("valid_after_xfer", bus.out_valid, 0);
  endtask

  initial begin
    logic [DATA_W-1:0] d;
    int                guard;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.cfg_we = 1'b0; bus.cfg_ch = '0;
    bus.cfg_sel = 2'd0; bus.cfg_data = '0; bus.out_ready = 1'b1;
    acc_flag = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset();

    // Identity on ch0.
    cfg_write(0, 0, 16'h0100);
    send(16'h1234, 0, 1'b0, '0);
    check("identity", bus.out_data[DATA_W-1:0], 16'h1234);

    // Low-pass step response on ch0 from clean state.
    do_reset();
    cfg_write(0, 0, 16'h0003);
    cfg_write(0, 1, 16'h0003);
    cfg_write(0, 2, 16'h00FC);
    send(16'h1000, 0, 1'b0, '0);
    check("lp_first", bus.out_data[DATA_W-1:0], 16'h0030);
    send(16'h1000, 0, 1'b0, '0);
    check("lp_second", bus.out_data[DATA_W-1:0], 16'h008F);

    // Negative b0 saturation on ch1, then negative zero.
    cfg_write(1, 0, 16'h8100);
    send(16'h8000, 0, 1'b0, '0);
    check("sat_value", bus.out_data[DATA_W +: DATA_W], 16'h7FFF);
    check("sat_flag", bus.out_sat[1], 1);
    cfg_write(1, 0, 16'h8000);
    send(16'h8000, 0, 1'b0, '0);
    check("negzero_value", bus.out_data[DATA_W +: DATA_W], 16'h0000);
    check("negzero_flag", bus.out_sat[1], 0);

    // Backpressure with a pending sample held on the input.
    send(16'h0777, 5, 1'b1, 16'h0100);
    send(16'h0100, 0, 1'b0, '0);

    // Coefficient change while the current sample is in MAC.
    cfg_write(0, 0, 16'h0100);
    cfg_write(0, 1, 16'h0000);
    cfg_write(0, 2, 16'h0000);
    acc_flag = 1'b0;
    fork
      send(16'h0100, 0, 1'b0, '0);
      begin
        guard = 0;
        while (!acc_flag && guard < 100) begin
          @(negedge clk);
          guard++;
        end
        @(negedge clk);
        @(negedge clk);
        cfg_write(0, 0, 16'h0200);
      end
    join
    check("old_b0_used", bus.out_data[DATA_W-1:0], 16'h0100);
    send(16'h0100, 0, 1'b0, '0);
    check("new_b0_used", bus.out_data[DATA_W-1:0], 16'h0200);

    // Reset in the third cycle of MAC, then a clean identity sample.
    bus.in_valid = 1'b1;
    bus.in_data  = 16'h4321;
    guard = 0;
    while (!bus.in_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();
    cfg_write(0, 0, 16'h0100);
    send(16'h5555, 0, 1'b0, '0);
    check("post_reset_identity", bus.out_data[DATA_W-1:0], 16'h5555);

    // Randomized coefficients and samples.
    for (int it = 0; it < 16; it++) begin
      for (int w = 0; w < 2; w++) begin
        if ($urandom_range(0, 3) == 0) d = DATA_W'($urandom);
        else d = {1'($urandom_range(0, 1)), 15'($urandom_range(0, 511))};
        cfg_write($urandom_range(0, N_CH - 1), $urandom_range(0, 3), d);
      end
      send(DATA_W'($urandom), $urandom_range(0, 2), 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
